serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder sequencer: time-multiplexes one full-adder cell across a WIDTH-bit addition, one bit per clock, LSB first.
- A carry flip-flop chains each bit's carry-out into the next bit.
- Sits between a requesting controller (start/done handshake) and the shared 1-bit adder.
- Trades latency for area in multi-bit arithmetic.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH), bit-index counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  initial carry; captured on accepted start.
- busy  output  1  high while a request is being processed (RUN).
- done  output  1  one-cycle pulse; sum/cout valid from this cycle on.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered final carry; held like sum.

Behaviour:
- Reset: every output is 0 (busy, done, sum, cout). FSM goes to IDLE; shift registers, carry FF and counter are cleared.
- Reset is synchronous, active-high, single clock domain.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, capture a, b and cin into the operand shift registers and the carry FF.
  - Clear the bit counter and go to RUN.
  - Without start, hold state and outputs.
- RUN:
  - busy=1.
  - Each cycle: feed the operand LSBs and carry FF to the adder cell, shift the sum bit into the result shift register MSB, shift both operands right by one, load carry FF with the cell carry-out, and increment the counter.
  - After the cycle with counter==WIDTH-1, go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - sum and cout registers load from the result shift register and carry FF on entry, so they are visible in the same cycle done is high.
  - Next state is IDLE unconditionally.
- Latency: start accepted at edge k -> busy high for cycles k+1..k+WIDTH -> done high in cycle k+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start in RUN or DONE is ignored, not queued. Operands are not re-sampled.
- a/b/cin changes after acceptance have no effect on the running operation.
- sum/cout change only when done is asserted; they are stable otherwise.
- Reset mid-RUN: abort, return to IDLE, outputs 0. No done pulse for the aborted operation.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on accepted start.
  - When sub=1, b is captured inverted and the carry FF is initialised to 1 (cin ignored), giving sum = a - b mod 2^WIDTH.
  - cout=1 means no borrow (a >= b, unsigned).
  - When sub=0, behaviour is identical to the undefined case.
- Undefined: no sub port; addition only.

Decomposition:
- Shared package (serial_arith_pkg):
  - State enum type {IDLE, RUN, DONE}.
  - Default WIDTH constant.
  - Localparam helper for CNT_W.
- One sub-module: the existing FullAdder cell, instantiated once, purely combinational.
- All sequencing, shift registers and the carry FF live in serial_add_ctrl.

Test Plan:
- Basic add, WIDTH=8: a=0x5A, b=0x3C, cin=0, start for 1 cycle -> busy high 8 cycles, then done pulse with sum=0x96, cout=0.
- Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- start held high throughout plus new operands (0x01, 0x01) driven mid-RUN -> first result 0x96 unaffected.
  - A second operation starts only from IDLE, one cycle after done.
  - Exactly one done per accepted start.
- Reset mid-operation: assert rst at the 4th RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0, FSM IDLE. A fresh start completes correctly.
- Result hold: after a done with sum=0x96, drive no start for 20 cycles -> sum/cout unchanged, done stays 0.
- With SERIAL_ADD_SUB_EN:
  - a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1.
  - a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
package serial_arith_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit-index counter width for a given operand width
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a controller and serial_add_ctrl.
// The sub request bit exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADD_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

`ifdef SERIAL_ADD_SUB_EN
   modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Single full-adder cell shared across all bit positions; purely combinational.
module serial_add_ctrl_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   // Sum and carry-out of one bit position
   always_comb begin
      s  = a ^ b ^ ci;
      co = (a & b) | (a & ci) | (b & ci);
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused for WIDTH cycles, LSB first.
// Define SERIAL_ADD_SUB_EN to add a subtract request (b inverted, carry seeded with 1).
module serial_add_ctrl
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   serial_add_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);
   localparam int unsigned RES_W = WIDTH - 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   // Holds the first WIDTH-1 sum bits; the last bit joins straight from the cell
   logic [RES_W-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] res_ext;

   serial_add_ctrl_fa u_fa (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // Next-state, datapath shifting and registered-output values
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sum_d   = sum_q;
      cout_d  = cout_q;
      res_ext = {fa_s, res_q};

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
`ifdef SERIAL_ADD_SUB_EN
               if (bus.sub) begin
                  b_d     = ~bus.b;
                  carry_d = 1'b1;
               end
`endif
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d   = res_ext[WIDTH-1:1];
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               // Final bit: publish the full result alongside the done pulse
               sum_d   = res_ext;
               cout_d  = fa_co;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH=8); covers subtract mode when
// SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

   localparam int unsigned WIDTH = 8;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one start pulse spanning exactly one rising edge
   task automatic do_start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
      @(negedge clk);
      bus.a     = av;
      bus.b     = bv;
      bus.cin   = cv;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Step negedges until done appears or the budget runs out, counting busy cycles
   task automatic wait_done(output int busy_cycles, output bit got);
      int i;
      busy_cycles = 0;
      got         = 1'b0;
      i           = 0;
      while (!got && i < int'(WIDTH) + 6) begin
         if (bus.done === 1'b1) begin
            got = 1'b1;
         end else begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
            i++;
         end
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      bus.sub   = 1'b0;
`endif
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.cout} !== 3'b000 || bus.sum !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, expected all 0",
                  bus.busy, bus.done, bus.sum, bus.cout);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_start: busy=%b done=%b, expected 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_basic_add();
      int bc;
      bit got;
      do_start(8'h5A, 8'h3C, 1'b0);
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_busy_first: busy=%b, expected 1", bus.busy);
      end
      wait_done(bc, got);
      n_checks++;
      if (!got || bc != 8) begin
         n_fail++;
         $display("FAIL basic_latency: got_done=%0d busy_cycles=%0d, expected 1 and 8", got, bc);
      end
      n_checks++;
      if (bus.sum !== 8'h96 || bus.cout !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_result: sum=%h cout=%b busy=%b, expected 96 0 0", bus.sum, bus.cout, bus.busy);
      end
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.sum !== 8'h96) begin
         n_fail++;
         $display("FAIL basic_done_pulse: done=%b sum=%h, expected 0 96", bus.done, bus.sum);
      end
   endtask

   task automatic test_carry_ripple();
      int bc;
      bit got;
      do_start(8'hFF, 8'h01, 1'b0);
      wait_done(bc, got);
      n_checks++;
      if (!got || bus.sum !== 8'h00 || bus.cout !== 1'b1) begin
         n_fail++;
         $display("FAIL ripple_ff_01: got_done=%0d sum=%h cout=%b, expected 1 00 1", got, bus.sum, bus.cout);
      end
      do_start(8'hFF, 8'h00, 1'b1);
      wait_done(bc, got);
      n_checks++;
      if (!got || bus.sum !== 8'h00 || bus.cout !== 1'b1) begin
         n_fail++;
         $display("FAIL ripple_ff_cin: got_done=%0d sum=%h cout=%b, expected 1 00 1", got, bus.sum, bus.cout);
      end
      do_start(8'hFF, 8'hFF, 1'b1);
      wait_done(bc, got);
      n_checks++;
      if (!got || bus.sum !== 8'hFF || bus.cout !== 1'b1) begin
         n_fail++;
         $display("FAIL ripple_ff_ff_cin: got_done=%0d sum=%h cout=%b, expected 1 ff 1", got, bus.sum, bus.cout);
      end
      do_start(8'hA5, 8'h5A, 1'b0);
      wait_done(bc, got);
      n_checks++;
      if (!got || bus.sum !== 8'hFF || bus.cout !== 1'b0) begin
         n_fail++;
         $display("FAIL no_carry_a5_5a: got_done=%0d sum=%h cout=%b, expected 1 ff 0", got, bus.sum, bus.cout);
      end
   endtask

   task automatic test_back_to_back();
      int bc;
      bit got;
      @(negedge clk);
      bus.a     = 8'h5A;
      bus.b     = 8'h3C;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.a     = 8'h01;
      bus.b     = 8'h01;
      wait_done(bc, got);
      n_checks++;
      if (!got || bc != 8 || bus.sum !== 8'h96 || bus.cout !== 1'b0) begin
         n_fail++;
         $display("FAIL held_first_result: got_done=%0d busy_cycles=%0d sum=%h cout=%b, expected 1 8 96 0",
                  got, bc, bus.sum, bus.cout);
      end
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL held_idle_gap: busy=%b done=%b, expected 0 0", bus.busy, bus.done);
      end
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL held_restart: busy=%b done=%b, expected 1 0", bus.busy, bus.done);
      end
      bus.start = 1'b0;
      wait_done(bc, got);
      n_checks++;
      if (!got || bc != 8 || bus.sum !== 8'h02 || bus.cout !== 1'b0) begin
         n_fail++;
         $display("FAIL held_second_result: got_done=%0d busy_cycles=%0d sum=%h cout=%b, expected 1 8 02 0",
                  got, bc, bus.sum, bus.cout);
      end
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL held_single_done: done=%b busy=%b, expected 0 0", bus.done, bus.busy);
      end
   endtask

   task automatic test_reset_mid_run();
      int bc;
      int dones;
      bit got;
      do_start(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.cout} !== 3'b000 || bus.sum !== 8'h00) begin
         n_fail++;
         $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b, expected all 0",
                  bus.busy, bus.done, bus.sum, bus.cout);
      end
      rst   = 1'b0;
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      end
      n_checks++;
      if (dones != 0) begin
         n_fail++;
         $display("FAIL midrun_no_done: activity_cycles=%0d, expected 0", dones);
      end
      do_start(8'h12, 8'h34, 1'b1);
      wait_done(bc, got);
      n_checks++;
      if (!got || bus.sum !== 8'h47 || bus.cout !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_fresh: got_done=%0d sum=%h cout=%b, expected 1 47 0", got, bus.sum, bus.cout);
      end
   endtask

   task automatic test_result_hold();
      int bc;
      bit got;
      do_start(8'h5A, 8'h3C, 1'b0);
      wait_done(bc, got);
      n_checks++;
      if (!got || bus.sum !== 8'h96) begin
         n_fail++;
         $display("FAIL hold_setup: got_done=%0d sum=%h, expected 1 96", got, bus.sum);
      end
      bus.a   = 8'hFF;
      bus.b   = 8'hFF;
      bus.cin = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.sum !== 8'h96 || bus.cout !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: sum=%h cout=%b done=%b, expected 96 0 0",
                     i, bus.sum, bus.cout, bus.done);
         end
      end
   endtask

`ifdef SERIAL_ADD_SUB_EN
   task automatic test_sub();
      int bc;
      bit got;
      bus.sub = 1'b1;
      do_start(8'h10, 8'h01, 1'b0);
      wait_done(bc, got);
      n_checks++;
      if (!got || bus.sum !== 8'h0F || bus.cout !== 1'b1) begin
         n_fail++;
         $display("FAIL sub_10_01: got_done=%0d sum=%h cout=%b, expected 1 0f 1", got, bus.sum, bus.cout);
      end
      do_start(8'h01, 8'h02, 1'b1);
      wait_done(bc, got);
      n_checks++;
      if (!got || bus.sum !== 8'hFF || bus.cout !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_01_02: got_done=%0d sum=%h cout=%b, expected 1 ff 0", got, bus.sum, bus.cout);
      end
      bus.sub = 1'b0;
      do_start(8'h10, 8'h01, 1'b0);
      wait_done(bc, got);
      n_checks++;
      if (!got || bus.sum !== 8'h11 || bus.cout !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_off_add: got_done=%0d sum=%h cout=%b, expected 1 11 0", got, bus.sum, bus.cout);
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_basic_add();
      test_carry_ripple();
      test_back_to_back();
      test_reset_mid_run();
      test_result_hold();
`ifdef SERIAL_ADD_SUB_EN
      test_sub();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
